// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: opcodes, FSM states and the helpers
// that decode an opcode into B-inversion and carry-in preset.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SLT  = 3'b011,
        OP_XOR  = 3'b100,
        OP_NOR  = 3'b101,
        OP_SUB  = 3'b110,
        OP_SLTU = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_arith(op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    endfunction

    // Subtract-style ops run as A + ~B + 1, so B inversion and carry-in preset coincide.
    function automatic logic op_binv(op_e op);
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    endfunction

    function automatic logic carry_preset(op_e op);
        return op_binv(op);
    endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational DIGIT-bit ALU slice: ripple adder plus bitwise logic ops.
module alu_digit
    import alu_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             binv,
    input  logic             cin,
    input  op_e              op,
    output logic [DIGIT-1:0] y,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] bx;
    logic [DIGIT-1:0] sum;

    always_comb begin
        bx   = b ^ {DIGIT{binv}};
        c    = '0;
        c[0] = cin;
        sum  = '0;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ bx[i] ^ c[i];
            c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
    end

    always_comb begin
        y = sum;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = sum;
        endcase
    end

    assign cout     = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: operands shift through one DIGIT slice per clock, LSB
// first; result and flags are registered and handed off by valid/ready.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, cflag_q, cflag_d, ovf_q, ovf_d;

    logic [DIGIT-1:0]       y;
    logic                   cout, c_msb_in;
    logic [WIDTH+DIGIT-1:0] cat;
    logic [WIDTH-1:0]       shifted, final_res;
    logic                   last;

    alu_digit #(.DIGIT(DIGIT)) u_digit (
        .a        (a_q[DIGIT-1:0]),
        .b        (b_q[DIGIT-1:0]),
        .binv     (op_binv(op_q)),
        .cin      (carry_q),
        .op       (op_q),
        .y        (y),
        .cout     (cout),
        .c_msb_in (c_msb_in)
    );

    always_comb begin
        cat       = {y, res_q};
        shifted   = cat[WIDTH+DIGIT-1:DIGIT];
        last      = (cnt_q == CW'(STEPS - 1));
        final_res = shifted;
        // Compares collapse to a single flag bit computed on the MSB slice.
        if (op_q == OP_SLT) begin
            final_res    = '0;
            final_res[0] = y[DIGIT-1] ^ (c_msb_in ^ cout);
        end else if (op_q == OP_SLTU) begin
            final_res    = '0;
            final_res[0] = ~cout;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        cflag_d     = cflag_q;
        ovf_d       = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    op_d    = op_e'(in_op);
                    res_d   = '0;
                    cnt_d   = '0;
                    carry_d = carry_preset(op_e'(in_op));
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                res_d = shifted;
                cnt_d = cnt_q + CW'(1);
                if (is_arith(op_q)) carry_d = cout;
                if (last) begin
                    result_d    = final_res;
                    zero_d      = (final_res == '0);
                    cflag_d     = is_arith(op_q) & cout;
                    ovf_d       = ((op_q == OP_ADD) || (op_q == OP_SUB)) & (c_msb_in ^ cout);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_AND;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            cflag_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            cflag_q     <= cflag_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign flag_zero  = zero_q;
    assign flag_carry = cflag_q;
    assign flag_ovf   = ovf_q;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: three configurations (8/1, 16/4, 8/8) driven with
// directed and random operations, checked against an arithmetic model.
module tb_alu_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv[3], ordy[3], ir[3], ov[3], fz[3], fc[3], fo[3];
    logic [2:0]  iop[3];
    logic [15:0] ia[3], ib[3];
    logic [7:0]  r0, r2;
    logic [15:0] r1;

    int n_chk = 0;
    int n_err = 0;

    alu_serial #(.WIDTH(8), .DIGIT(1)) u_dut0 (
        .clock(clk), .reset_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_a(ia[0][7:0]), .in_b(ib[0][7:0]), .in_op(iop[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .result(r0), .flag_zero(fz[0]), .flag_carry(fc[0]),
        .flag_ovf(fo[0]));

    alu_serial #(.WIDTH(16), .DIGIT(4)) u_dut1 (
        .clock(clk), .reset_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_a(ia[1]), .in_b(ib[1]), .in_op(iop[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .result(r1), .flag_zero(fz[1]), .flag_carry(fc[1]),
        .flag_ovf(fo[1]));

    alu_serial #(.WIDTH(8), .DIGIT(8)) u_dut2 (
        .clock(clk), .reset_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_a(ia[2][7:0]), .in_b(ib[2][7:0]), .in_op(iop[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .result(r2), .flag_zero(fz[2]), .flag_carry(fc[2]),
        .flag_ovf(fo[2]));

    function automatic int width_of(int d);
        return (d == 1) ? 16 : 8;
    endfunction

    function automatic int steps_of(int d);
        case (d)
            0:       return 8;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] get_res(int d);
        case (d)
            0:       return {8'h00, r0};
            1:       return r1;
            default: return {8'h00, r2};
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Behavioural reference: plain integer arithmetic modulo 2^w.
    task automatic model(int w, logic [2:0] op, logic [15:0] a, logic [15:0] b,
                         output logic [15:0] r, output logic z, output logic c, output logic v);
        longint mask, am, bm, s, sa, sb, rr;
        mask = (longint'(1) << w) - 1;
        am = longint'(a) & mask;
        bm = longint'(b) & mask;
        sa = ((am >> (w - 1)) & 1) != 0 ? am - (longint'(1) << w) : am;
        sb = ((bm >> (w - 1)) & 1) != 0 ? bm - (longint'(1) << w) : bm;
        rr = 0; c = 1'b0; v = 1'b0;
        case (op)
            3'b000: rr = am & bm;
            3'b001: rr = am | bm;
            3'b100: rr = am ^ bm;
            3'b101: rr = ~(am | bm) & mask;
            3'b010: begin
                s = am + bm; rr = s & mask; c = ((s >> w) & 1) != 0;
                v = (sa >= 0) == (sb >= 0) && ((sa + sb) > (mask >> 1) || (sa + sb) < -((mask >> 1) + 1));
            end
            3'b110: begin
                s = am + ((~bm) & mask) + 1; rr = s & mask; c = ((s >> w) & 1) != 0;
                v = ((sa - sb) > (mask >> 1)) || ((sa - sb) < -((mask >> 1) + 1));
            end
            3'b011: begin rr = (sa < sb) ? 1 : 0; c = (am >= bm); end
            default: begin rr = (am < bm) ? 1 : 0; c = (am >= bm); end
        endcase
        r = rr[15:0];
        z = (rr == 0);
    endtask

    task automatic send(int d, logic [2:0] op, logic [15:0] a, logic [15:0] b);
        int k;
        iop[d] = op; ia[d] = a; ib[d] = b; iv[d] = 1'b1;
        k = 0;
        while (!ir[d] && k < 50) begin
            @(posedge clk); #1; k++;
        end
        check("accept_wait", 32'(k < 50), 32'd1);
        @(posedge clk); #1;
        iv[d] = 1'b0;
    endtask

    task automatic verify(int d, string tag, logic [2:0] op, logic [15:0] a, logic [15:0] b);
        int lat;
        logic [15:0] er;
        logic ez, ec, ev;
        model(width_of(d), op, a, b, er, ez, ec, ev);
        lat = 0;
        while (!ov[d] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(steps_of(d)));
        check({tag, "_res"}, 32'(get_res(d)), 32'(er));
        check({tag, "_z"}, 32'(fz[d]), 32'(ez));
        check({tag, "_c"}, 32'(fc[d]), 32'(ec));
        check({tag, "_v"}, 32'(fo[d]), 32'(ev));
    endtask

    task automatic release_out(int d, string tag);
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
        check({tag, "_rel_ov"}, 32'(ov[d]), 32'd0);
        check({tag, "_rel_ir"}, 32'(ir[d]), 32'd1);
    endtask

    task automatic run(int d, string tag, logic [2:0] op, logic [15:0] a, logic [15:0] b);
        send(d, op, a, b);
        verify(d, tag, op, a, b);
        release_out(d, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] snap;
        logic [2:0]  op;
        logic [15:0] a, b, m;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; iop[d] = 3'b000; ia[d] = '0; ib[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_ir", 32'(ir[d]), 32'd1);
            check("rst_ov", 32'(ov[d]), 32'd0);
            check("rst_res", 32'(get_res(d)), 32'd0);
            check("rst_flags", 32'({fz[d], fc[d], fo[d]}), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, "add_ff_01", 3'b010, 16'h00FF, 16'h0001);
        run(0, "sub_80_01", 3'b110, 16'h0080, 16'h0001);
        run(0, "sub_05_05", 3'b110, 16'h0005, 16'h0005);
        run(0, "slt_ff_01", 3'b011, 16'h00FF, 16'h0001);
        run(0, "sltu_ff_01", 3'b111, 16'h00FF, 16'h0001);
        run(0, "slt_7f_80", 3'b011, 16'h007F, 16'h0080);
        run(0, "and", 3'b000, 16'h00F0, 16'h003C);
        run(0, "or", 3'b001, 16'h00F0, 16'h003C);
        run(0, "xor", 3'b100, 16'h00F0, 16'h003C);
        run(0, "nor", 3'b101, 16'h00F0, 16'h003C);

        // Backpressure with a second operation already waiting at the input.
        send(0, 3'b010, 16'h003A, 16'h0011);
        verify(0, "bp_first", 3'b010, 16'h003A, 16'h0011);
        snap = get_res(0);
        iop[0] = 3'b110; ia[0] = 16'h0020; ib[0] = 16'h0030; iv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_ov", 32'(ov[0]), 32'd1);
            check("bp_ir", 32'(ir[0]), 32'd0);
            check("bp_res", 32'(get_res(0)), 32'(snap));
            check("bp_flags", 32'({fz[0], fc[0], fo[0]}), 32'b000);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        check("bp_idle_ir", 32'(ir[0]), 32'd1);
        check("bp_idle_ov", 32'(ov[0]), 32'd0);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        check("bp_accepted", 32'(ir[0]), 32'd0);
        verify(0, "bp_second", 3'b110, 16'h0020, 16'h0030);
        release_out(0, "bp_second");

        // Reset during RUN after three slices have been processed.
        send(0, 3'b010, 16'h0055, 16'h0066);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ov", 32'(ov[0]), 32'd0);
        check("midrst_ir", 32'(ir[0]), 32'd1);
        check("midrst_res", 32'(get_res(0)), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 3'b010, 16'h0012, 16'h0034);
        verify(0, "post_rst", 3'b010, 16'h0012, 16'h0034);
        check("post_rst_46", 32'(get_res(0)), 32'h46);
        release_out(0, "post_rst");

        send(1, 3'b010, 16'h7FFF, 16'h0001);
        verify(1, "w16_add", 3'b010, 16'h7FFF, 16'h0001);
        check("w16_8000", 32'(get_res(1)), 32'h8000);
        check("w16_ovf", 32'(fo[1]), 32'd1);
        release_out(1, "w16_add");
        run(2, "w8d8_add", 3'b010, 16'h007F, 16'h0001);

        for (int d = 0; d < 3; d++) begin
            m = (width_of(d) == 16) ? 16'hFFFF : 16'h00FF;
            for (int i = 0; i < 30; i++) begin
                op = 3'($urandom_range(0, 7));
                a = 16'($urandom) & m;
                b = 16'($urandom) & m;
                if (i % 5 == 0) a = b;
                send(d, op, a, b);
                verify(d, "rand", op, a, b);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                release_out(d, "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
